// File: rtl/enigma_ctrl.sv
// ---------------------------------------------------------------------------
// enigma_ctrl
// Per-character sequencer for a three-rotor Enigma datapath. Accepts one
// ASCII character per valid/ready handshake, steps the rotor positions like
// an odometer and routes letters through the external rotors one at a time
// (0->1->2 to encode, 2->1->0 to decode). The result is returned on a
// one-cycle out_valid strobe. Non-letters bypass the rotors unchanged.
//
// Parameters:
//   TIMEOUT   max WAIT cycles per rotor before error (1..65535)
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   cfg_load, cfg_pos     load rotor start positions (rotor k at [5k+:5])
//   in_valid/in_ready     character input handshake
//   in_char, in_dec       input character and direction (1 = decode)
//   out_valid, out_char   result strobe and held result
//   rot_set               configuration strobe to all rotors
//   rot_en, rot_valid     per-rotor step and character-issue strobes
//   rot_din, rot_dec      shared character bus and direction to rotors
//   rot_done, rot_dout    per-rotor completion and results (rotor k at [8k+:8])
//   pos                   current rotor positions
//   busy, err             controller not idle, sticky timeout flag
//
// Build option:
//   ENIGMA_CTRL_TIMEOUT_EN  enables the per-rotor WAIT watchdog and ERR state.
// ---------------------------------------------------------------------------
module enigma_ctrl #(
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        cfg_load,
   input  logic [14:0] cfg_pos,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_char,
   input  logic        in_dec,
   output logic        out_valid,
   output logic [7:0]  out_char,
   output logic        rot_set,
   output logic [2:0]  rot_en,
   output logic [2:0]  rot_valid,
   output logic [7:0]  rot_din,
   output logic        rot_dec,
   input  logic [2:0]  rot_done,
   input  logic [23:0] rot_dout,
   output logic [14:0] pos,
   output logic        busy,
   output logic        err
);

   localparam int unsigned NROT = 3;
   localparam int unsigned PW   = 5;
   localparam int unsigned CW   = 8;
   localparam int unsigned SW   = 2;

   // Elaboration-time guard on the watchdog range
   if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
      $error("enigma_ctrl: TIMEOUT must be within 1..65535");
   end

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_STEP  = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_OUT   = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   state_t               r_state, w_state_nxt;
   logic [SW-1:0]        r_stage, w_stage_nxt;
   logic [CW-1:0]        r_char, w_char_nxt;
   logic                 r_dec, w_dec_nxt;
   logic [NROT*PW-1:0]   r_pos, w_pos_nxt;
   logic                 r_err, w_err_nxt;
   logic [CW-1:0]        r_out_char, w_out_char_nxt;
   logic                 r_out_valid;
   logic                 r_busy;
   logic                 r_rot_set, w_set_nxt;
   logic [NROT-1:0]      r_rot_en, w_en_nxt;
   logic [NROT-1:0]      r_rot_valid, w_valid_nxt;
   logic [SW-1:0]        w_k, w_k_nxt;
   logic                 w_done_k;
   logic [CW-1:0]        w_dout_k;
   logic [NROT*PW-1:0]   w_cfg_pos;
   logic [PW-1:0]        w_p0, w_p1, w_p2;
   logic                 w_p0_max, w_p1_max;
   logic                 w_is_letter;
   logic                 w_timeout;

   // Position increment with 25 -> 0 wrap
   function automatic logic [PW-1:0] f_wrap_inc(input logic [PW-1:0] p);
      return (p == PW'(25)) ? '0 : p + PW'(1);
   endfunction

   // Out-of-range start positions load as 0
   function automatic logic [PW-1:0] f_sanitize(input logic [PW-1:0] p);
      return (p >= PW'(26)) ? '0 : p;
   endfunction

   assign w_p0        = r_pos[PW-1:0];
   assign w_p1        = r_pos[2*PW-1:PW];
   assign w_p2        = r_pos[3*PW-1:2*PW];
   assign w_p0_max    = (w_p0 == PW'(25));
   assign w_p1_max    = (w_p1 == PW'(25));
   assign w_is_letter = (in_char >= CW'(65)) && (in_char <= CW'(90));

   // Active rotor for the current stage: stage order reversed when decoding
   assign w_k = r_dec ? (SW'(2) - r_stage) : r_stage;

   // Select completion and result of the active rotor only
   always_comb begin
      w_done_k = 1'b0;
      w_dout_k = '0;
      case (w_k)
         2'd0:    begin w_done_k = rot_done[0]; w_dout_k = rot_dout[7:0];   end
         2'd1:    begin w_done_k = rot_done[1]; w_dout_k = rot_dout[15:8];  end
         default: begin w_done_k = rot_done[2]; w_dout_k = rot_dout[23:16]; end
      endcase
   end

   // Sanitised configuration positions
   always_comb begin
      w_cfg_pos = '0;
      for (int k = 0; k < NROT; k++) begin
         w_cfg_pos[k*PW +: PW] = f_sanitize(cfg_pos[k*PW +: PW]);
      end
   end

`ifdef ENIGMA_CTRL_TIMEOUT_EN
   localparam int unsigned WDW = 16;
   localparam int unsigned WCW = WDW + 1;

   logic [WDW-1:0] r_wdog;

   // Watchdog: cleared on each issue, counts WAIT cycles
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wdog <= '0;
      end else if (r_state == S_ISSUE) begin
         r_wdog <= '0;
      end else if (r_state == S_WAIT) begin
         r_wdog <= r_wdog + WDW'(1);
      end
   end

   // Fires in the WAIT cycle that brings the count to TIMEOUT
   assign w_timeout = (WCW'(r_wdog) + WCW'(1)) >= WCW'(TIMEOUT);
`else
   assign w_timeout = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state, datapath next values and next-cycle strobes
   always_comb begin
      w_state_nxt    = r_state;
      w_stage_nxt    = r_stage;
      w_char_nxt     = r_char;
      w_dec_nxt      = r_dec;
      w_pos_nxt      = r_pos;
      w_err_nxt      = r_err;
      w_out_char_nxt = r_out_char;
      w_set_nxt      = 1'b0;
      w_en_nxt       = '0;
      w_valid_nxt    = '0;
      w_k_nxt        = '0;

      case (r_state)
         S_IDLE: begin
            // Configuration takes priority over a simultaneous character
            if (cfg_load) begin
               w_pos_nxt = w_cfg_pos;
               w_set_nxt = 1'b1;
               w_err_nxt = 1'b0;
            end else if (in_valid && !r_err) begin
               w_char_nxt  = in_char;
               w_dec_nxt   = in_dec;
               w_stage_nxt = '0;
               if (w_is_letter) begin
                  w_state_nxt = S_STEP;
               end else begin
                  w_out_char_nxt = in_char;
                  w_state_nxt    = S_OUT;
               end
            end
         end

         S_STEP: begin
            w_pos_nxt[PW-1:0] = f_wrap_inc(w_p0);
            if (w_p0_max) begin
               w_pos_nxt[2*PW-1:PW] = f_wrap_inc(w_p1);
            end
            if (w_p0_max && w_p1_max) begin
               w_pos_nxt[3*PW-1:2*PW] = f_wrap_inc(w_p2);
            end
            w_state_nxt = S_ISSUE;
         end

         S_ISSUE: begin
            w_state_nxt = S_WAIT;
         end

         S_WAIT: begin
            if (w_done_k) begin
               w_char_nxt = w_dout_k;
               if (r_stage == SW'(2)) begin
                  w_out_char_nxt = w_dout_k;
                  w_state_nxt    = S_OUT;
               end else begin
                  w_stage_nxt = r_stage + SW'(1);
                  w_state_nxt = S_ISSUE;
               end
            end else if (w_timeout) begin
               w_err_nxt   = 1'b1;
               w_state_nxt = S_ERR;
            end
         end

         S_OUT: begin
            w_state_nxt = S_IDLE;
         end

         S_ERR: begin
            if (cfg_load) begin
               w_pos_nxt   = w_cfg_pos;
               w_set_nxt   = 1'b1;
               w_err_nxt   = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Step strobes use the pre-step positions
      if (w_state_nxt == S_STEP) begin
         w_en_nxt = {w_p0_max & w_p1_max, w_p0_max, 1'b1};
      end

      // Issue strobe to the rotor serving the upcoming stage
      if (w_state_nxt == S_ISSUE) begin
         w_k_nxt = w_dec_nxt ? (SW'(2) - w_stage_nxt) : w_stage_nxt;
         case (w_k_nxt)
            2'd0:    w_valid_nxt = 3'b001;
            2'd1:    w_valid_nxt = 3'b010;
            default: w_valid_nxt = 3'b100;
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stage     <= '0;
         r_char      <= '0;
         r_dec       <= 1'b0;
         r_pos       <= '0;
         r_err       <= 1'b0;
         r_out_char  <= '0;
         r_out_valid <= 1'b0;
         r_busy      <= 1'b0;
         r_rot_set   <= 1'b0;
         r_rot_en    <= '0;
         r_rot_valid <= '0;
      end else begin
         r_stage     <= w_stage_nxt;
         r_char      <= w_char_nxt;
         r_dec       <= w_dec_nxt;
         r_pos       <= w_pos_nxt;
         r_err       <= w_err_nxt;
         r_out_char  <= w_out_char_nxt;
         r_out_valid <= (w_state_nxt == S_OUT);
         r_busy      <= (w_state_nxt != S_IDLE);
         r_rot_set   <= w_set_nxt;
         r_rot_en    <= w_en_nxt;
         r_rot_valid <= w_valid_nxt;
      end
   end

   // Ready drops immediately on cfg_load so configuration always wins
   assign in_ready  = (r_state == S_IDLE) & ~cfg_load & ~r_err & ~reset;
   assign out_valid = r_out_valid;
   assign out_char  = r_out_char;
   assign rot_set   = r_rot_set;
   assign rot_en    = r_rot_en;
   assign rot_valid = r_rot_valid;
   assign rot_din   = r_char;
   assign rot_dec   = r_dec;
   assign pos       = r_pos;
   assign busy      = r_busy;
   assign err       = r_err;

endmodule

// File: tb/tb_enigma_ctrl.sv
// ---------------------------------------------------------------------------
// tb_enigma_ctrl
// Directed bench for enigma_ctrl. Stub rotors return din+1 after W cycles.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
// ---------------------------------------------------------------------------
module tb_enigma_ctrl;

   localparam int W = 2;

   logic        clk;
   logic        reset;
   logic        cfg_load;
   logic [14:0] cfg_pos;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_char;
   logic        in_dec;
   logic        out_valid;
   logic [7:0]  out_char;
   logic        rot_set;
   logic [2:0]  rot_en;
   logic [2:0]  rot_valid;
   logic [7:0]  rot_din;
   logic        rot_dec;
   logic [2:0]  rot_done;
   logic [23:0] rot_dout;
   logic [14:0] pos;
   logic        busy;
   logic        err;

   int n_cmp = 0;
   int n_bad = 0;

   enigma_ctrl #(.TIMEOUT(8)) dut (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pos(cfg_pos),
      .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_dec(in_dec),
      .out_valid(out_valid), .out_char(out_char), .rot_set(rot_set),
      .rot_en(rot_en), .rot_valid(rot_valid), .rot_din(rot_din), .rot_dec(rot_dec),
      .rot_done(rot_done), .rot_dout(rot_dout), .pos(pos), .busy(busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stub rotors: capture din+1 on rot_valid, raise done in the W-th cycle after
   int         st_cnt  [3];
   logic [7:0] st_data [3];
   logic [2:0] stub_done;
   logic [2:0] man_done;
   logic       man_mode;

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (rot_valid[k]) begin
            st_cnt[k]  <= W;
            st_data[k] <= rot_din + 8'd1;
         end else if (st_cnt[k] != 0) begin
            st_cnt[k] <= st_cnt[k] - 1;
         end
      end
   end

   always_comb begin
      for (int k = 0; k < 3; k++) stub_done[k] = (st_cnt[k] == 1);
   end

   assign rot_done = man_mode ? man_done : stub_done;
   assign rot_dout = {st_data[2], st_data[1], st_data[0]};

   // Per-character observations
   int         cyc_out;
   logic [7:0] got_char;
   logic [2:0] en_at1;
   logic [2:0] en_or;
   logic       dec_at_issue;
   logic [2:0] vseq [$];
   logic [8:0] seqv;

   task automatic do_cfg(input logic [14:0] p);
      cfg_pos  = p;
      cfg_load = 1'b1;
      @(negedge clk);
      cfg_load = 1'b0;
   endtask

   // Handshake at the next rising edge (T); returns in cycle T+cyc_out+1
   task automatic send_char(input logic [7:0] c, input logic d);
      cyc_out = -1; vseq.delete(); en_or = '0; en_at1 = '0;
      dec_at_issue = 1'b0; got_char = '0;
      in_char = c; in_dec = d; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int n = 1; n <= 60; n++) begin
         if (n == 1) en_at1 = rot_en;
         en_or = en_or | rot_en;
         if (rot_valid != 3'b000) begin
            vseq.push_back(rot_valid);
            dec_at_issue = rot_dec;
         end
         if (out_valid) begin
            cyc_out  = n;
            got_char = out_char;
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      seqv = (vseq.size() == 3) ? {vseq[0], vseq[1], vseq[2]} : 9'h1ff;
   endtask

   task automatic test_reset();
      logic [42:0] snap;
      repeat (3) @(negedge clk);
      snap = {in_ready, out_valid, out_char, rot_set, rot_en, rot_valid,
              rot_din, rot_dec, pos, busy, err};
      n_cmp++; if (snap !== 43'd0) begin n_bad++; $display("FAIL reset_outputs: got %h expected 0", snap); end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
   endtask

   task automatic test_encode();
      do_cfg(15'd0);
      n_cmp++; if (rot_set !== 1'b1) begin n_bad++; $display("FAIL cfg_rot_set: got %b expected 1", rot_set); end
      send_char(8'd65, 1'b0);
      n_cmp++; if (seqv !== 9'b001_010_100) begin n_bad++; $display("FAIL enc_order: got %b expected 001010100", seqv); end
      n_cmp++; if (cyc_out !== 11) begin n_bad++; $display("FAIL enc_latency: got %0d expected 11", cyc_out); end
      n_cmp++; if (got_char !== 8'd68) begin n_bad++; $display("FAIL enc_char: got %0d expected 68", got_char); end
      n_cmp++; if (pos !== 15'd1) begin n_bad++; $display("FAIL enc_pos: got %h expected 0001", pos); end
      n_cmp++; if (en_at1 !== 3'b001) begin n_bad++; $display("FAIL enc_step: got %b expected 001", en_at1); end
      n_cmp++; if ({in_ready, out_valid, out_char, busy} !== {1'b1, 1'b0, 8'd68, 1'b0})
         begin n_bad++; $display("FAIL enc_idle_hold: got rdy=%b ov=%b oc=%0d busy=%b expected 1 0 68 0", in_ready, out_valid, out_char, busy); end
   endtask

   task automatic test_decode();
      send_char(8'd68, 1'b1);
      n_cmp++; if (seqv !== 9'b100_010_001) begin n_bad++; $display("FAIL dec_order: got %b expected 100010001", seqv); end
      n_cmp++; if (dec_at_issue !== 1'b1) begin n_bad++; $display("FAIL dec_rot_dec: got %b expected 1", dec_at_issue); end
      n_cmp++; if (got_char !== 8'd71) begin n_bad++; $display("FAIL dec_char: got %0d expected 71", got_char); end
      n_cmp++; if (cyc_out !== 11) begin n_bad++; $display("FAIL dec_latency: got %0d expected 11", cyc_out); end
      n_cmp++; if (pos !== 15'd2) begin n_bad++; $display("FAIL dec_pos: got %h expected 0002", pos); end
   endtask

   task automatic test_odometer();
      do_cfg({5'd0, 5'd25, 5'd25});
      send_char(8'd65, 1'b0);
      n_cmp++; if (en_at1 !== 3'b111) begin n_bad++; $display("FAIL odo_en_full: got %b expected 111", en_at1); end
      n_cmp++; if (pos !== {5'd1, 5'd0, 5'd0}) begin n_bad++; $display("FAIL odo_pos_full: got %h expected %h", pos, {5'd1, 5'd0, 5'd0}); end
      n_cmp++; if (got_char !== 8'd68) begin n_bad++; $display("FAIL odo_char: got %0d expected 68", got_char); end
      do_cfg({5'd4, 5'd3, 5'd25});
      send_char(8'd66, 1'b0);
      n_cmp++; if (en_at1 !== 3'b011) begin n_bad++; $display("FAIL odo_en_part: got %b expected 011", en_at1); end
      n_cmp++; if (pos !== {5'd4, 5'd4, 5'd0}) begin n_bad++; $display("FAIL odo_pos_part: got %h expected %h", pos, {5'd4, 5'd4, 5'd0}); end
      do_cfg({5'd25, 5'd25, 5'd25});
      send_char(8'd67, 1'b0);
      n_cmp++; if (pos !== 15'd0) begin n_bad++; $display("FAIL odo_pos_wrap: got %h expected 0000", pos); end
      do_cfg({5'd31, 5'd26, 5'd7});
      n_cmp++; if (pos !== {5'd0, 5'd0, 5'd7}) begin n_bad++; $display("FAIL cfg_sanitize: got %h expected %h", pos, {5'd0, 5'd0, 5'd7}); end
   endtask

   task automatic test_passthrough();
      do_cfg({5'd0, 5'd0, 5'd5});
      send_char(8'd32, 1'b0);
      n_cmp++; if (cyc_out !== 1) begin n_bad++; $display("FAIL pass_latency: got %0d expected 1", cyc_out); end
      n_cmp++; if (got_char !== 8'd32) begin n_bad++; $display("FAIL pass_char: got %0d expected 32", got_char); end
      n_cmp++; if ({en_or, 3'(vseq.size())} !== 6'd0) begin n_bad++; $display("FAIL pass_no_rotor: got en=%b issues=%0d expected 0 0", en_or, vseq.size()); end
      n_cmp++; if (pos !== {5'd0, 5'd0, 5'd5}) begin n_bad++; $display("FAIL pass_pos: got %h expected %h", pos, {5'd0, 5'd0, 5'd5}); end
      send_char(8'd64, 1'b0);
      n_cmp++; if ({cyc_out[7:0], got_char} !== {8'd1, 8'd64}) begin n_bad++; $display("FAIL pass_at: got lat=%0d ch=%0d expected 1 64", cyc_out, got_char); end
      send_char(8'd91, 1'b0);
      n_cmp++; if ({cyc_out[7:0], got_char} !== {8'd1, 8'd91}) begin n_bad++; $display("FAIL pass_bracket: got lat=%0d ch=%0d expected 1 91", cyc_out, got_char); end
      send_char(8'd90, 1'b0);
      n_cmp++; if ({cyc_out[7:0], got_char} !== {8'd11, 8'd93}) begin n_bad++; $display("FAIL letter_z: got lat=%0d ch=%0d expected 11 93", cyc_out, got_char); end
   endtask

   task automatic test_collision();
      int hits;
      cfg_pos = {5'd0, 5'd0, 5'd9}; cfg_load = 1'b1;
      in_char = 8'd66; in_dec = 1'b0; in_valid = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL coll_ready: got %b expected 0", in_ready); end
      @(negedge clk);
      cfg_load = 1'b0; in_valid = 1'b0;
      n_cmp++; if ({rot_set, busy} !== 2'b10) begin n_bad++; $display("FAIL coll_set: got set=%b busy=%b expected 1 0", rot_set, busy); end
      n_cmp++; if (pos !== {5'd0, 5'd0, 5'd9}) begin n_bad++; $display("FAIL coll_pos: got %h expected %h", pos, {5'd0, 5'd0, 5'd9}); end
      hits = 0;
      for (int n = 0; n < 15; n++) begin
         @(negedge clk);
         if (rot_en != 0 || rot_valid != 0 || out_valid || rot_set) hits++;
      end
      n_cmp++; if (hits !== 0) begin n_bad++; $display("FAIL coll_no_handshake: got %0d active cycles expected 0", hits); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] c1, c2;
      int l1, l2;
      do_cfg(15'd0);
      send_char(8'd72, 1'b0); c1 = got_char; l1 = cyc_out;
      send_char(8'd73, 1'b0); c2 = got_char; l2 = cyc_out;
      n_cmp++; if ({c1, c2} !== {8'd75, 8'd76}) begin n_bad++; $display("FAIL b2b_chars: got %0d %0d expected 75 76", c1, c2); end
      n_cmp++; if (l1 !== 11 || l2 !== 11) begin n_bad++; $display("FAIL b2b_latency: got %0d %0d expected 11 11", l1, l2); end
      n_cmp++; if (pos !== 15'd2) begin n_bad++; $display("FAIL b2b_pos: got %h expected 0002", pos); end
   endtask

   task automatic test_reset_mid_char();
      do_cfg({5'd0, 5'd0, 5'd3});
      in_char = 8'd65; in_dec = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if ({busy, pos} !== {1'b1, 5'd0, 5'd0, 5'd4}) begin n_bad++; $display("FAIL mid_pre: got busy=%b pos=%h expected 1 0004", busy, pos); end
      reset = 1'b1;
      #1;
      n_cmp++; if ({in_ready, out_valid, out_char, rot_en, rot_valid, rot_din, pos, busy, err} !== 40'd0)
         begin n_bad++; $display("FAIL mid_reset_outputs: got ov=%b pos=%h busy=%b din=%0d expected all 0", out_valid, pos, busy, rot_din); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_cmp++; if ({in_ready, busy, pos} !== {1'b1, 1'b0, 15'd0}) begin n_bad++; $display("FAIL mid_release: got rdy=%b busy=%b pos=%h expected 1 0 0000", in_ready, busy, pos); end
   endtask

   task automatic test_wait_timeout();
      man_mode = 1'b1; man_done = 3'b000;
      do_cfg(15'd0);
      in_char = 8'd65; in_dec = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL wd_before: got %b expected 0", err); end
      @(negedge clk);
`ifdef ENIGMA_CTRL_TIMEOUT_EN
      begin
         int outs;
         n_cmp++; if ({err, busy, in_ready} !== 3'b110) begin n_bad++; $display("FAIL wd_err: got err=%b busy=%b rdy=%b expected 1 1 0", err, busy, in_ready); end
         outs = 0;
         in_valid = 1'b1;
         for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (out_valid || in_ready) outs++;
         end
         in_valid = 1'b0;
         n_cmp++; if ({outs, err} !== {32'd0, 1'b1}) begin n_bad++; $display("FAIL wd_stuck: got %0d events err=%b expected 0 1", outs, err); end
         man_mode = 1'b0;
         do_cfg(15'd0);
         n_cmp++; if ({err, in_ready, rot_set, busy} !== 4'b0110) begin n_bad++; $display("FAIL wd_clear: got err=%b rdy=%b set=%b busy=%b expected 0 1 1 0", err, in_ready, rot_set, busy); end
      end
`else
      begin
         int lat;
         repeat (20) @(negedge clk);
         n_cmp++; if ({err, busy, in_ready} !== 3'b010) begin n_bad++; $display("FAIL nowd_wait: got err=%b busy=%b rdy=%b expected 0 1 0", err, busy, in_ready); end
         man_done = 3'b001;
         @(negedge clk);
         man_done = 3'b000; man_mode = 1'b0;
         lat = -1; got_char = '0;
         for (int n = 1; n <= 20; n++) begin
            if (out_valid) begin lat = n; got_char = out_char; break; end
            @(negedge clk);
         end
         n_cmp++; if ({lat[7:0], got_char} !== {8'd7, 8'd68}) begin n_bad++; $display("FAIL nowd_resume: got lat=%0d ch=%0d expected 7 68", lat, got_char); end
         @(negedge clk);
      end
`endif
   endtask

   initial begin
      reset = 1'b1; cfg_load = 1'b0; cfg_pos = '0;
      in_valid = 1'b0; in_char = '0; in_dec = 1'b0;
      man_mode = 1'b0; man_done = '0;
      test_reset();
      test_encode();
      test_decode();
      test_odometer();
      test_passthrough();
      test_collision();
      test_back_to_back();
      test_reset_mid_char();
      test_wait_timeout();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete within 200000 time units");
      $fatal(1, "bench timeout");
   end

endmodule
